mem_write_ctrl: RTL
===================

# mem_write_ctrl

Downstream consumer of the button-to-write decoder. Turns its level-held `enable`/`addr`/`data` request into exactly one memory write per press. Captures the rising edge of `enable` into a small request FIFO, then drains the FIFO through a registered write port with an acknowledge handshake. Optionally reads each word back and flags mismatches.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `DEPTH`, default 4: request FIFO entries; must be a power of two and at least 2.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  write request level from the decoder.
- `addr`  in  ADDR_W  request address; valid while `enable`=1.
- `data`  in  DATA_W  request data; valid while `enable`=1.
- `mem_we`  out  1  write strobe; held until `mem_ack`.
- `mem_re`  out  1  readback strobe; constant 0 unless the verify feature is compiled in.
- `mem_addr`  out  ADDR_W  registered memory address.
- `mem_wdata`  out  DATA_W  registered write data.
- `mem_ack`  in  1  memory completion for the current `mem_we`/`mem_re`.
- `mem_rdata`  in  DATA_W  readback data; valid with `mem_ack` during a read.
- `busy`  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- `overflow`  out  1  sticky; a request was dropped because the FIFO was full.
- `err`  out  1  sticky; a readback did not match the written data.
- `wr_count`  out  8  count of completed writes; wraps from 255 to 0.

## Operation
- Edge detect:
  - `en_q` samples `enable` each cycle. Reset value of `en_q` is 1, so `enable` already high at reset release is not a press.
  - A push is generated when `enable`=1 and `en_q`=0. The push captures {`addr`,`data`} of that same cycle.
- FIFO:
  - `DEPTH` entries, read and write pointers with a wrap bit.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and `overflow` is set. `overflow` clears only on reset.
  - A simultaneous push and pop when the FIFO is empty is impossible, because a pop requires an entry.
- FSM states: IDLE, WRITE, and with the verify feature also READ.
  - IDLE: if the FIFO is non-empty, load the head into `mem_addr`/`mem_wdata`, assert `mem_we`, and go to WRITE.
  - WRITE: hold `mem_we`, `mem_addr` and `mem_wdata` stable. On `mem_ack`=1:
    - pop the FIFO;
    - increment `wr_count`;
    - deassert `mem_we`;
    - go to IDLE, or to READ when verify is compiled in.
  - READ: assert `mem_re` with the same `mem_addr`. On `mem_ack`=1:
    - compare `mem_rdata` with `mem_wdata`; on mismatch set `err`;
    - deassert `mem_re`;
    - go to IDLE.
- A `mem_ack` seen in IDLE is ignored.
- Reset values: all outputs 0 (`mem_we`, `mem_re`, `mem_addr`, `mem_wdata`, `busy`, `overflow`, `err`, `wr_count`); FIFO empty; FSM in IDLE.
- Reset mid-operation: asserting `rst_n` low drops `mem_we`/`mem_re` immediately, without waiting for a clock edge. Queued requests are discarded.

## Timing
- Press edge at cycle N:
  - entry visible in the FIFO at N+1;
  - `mem_we` high from N+2 if the FSM was IDLE with an empty FIFO.
- `mem_ack` sampled high at cycle M:
  - `mem_we` low at M+1;
  - next write at the earliest at M+2, because one IDLE cycle is always inserted between transactions.
- `mem_ack` may be high in the same cycle `mem_we` first rises; the minimum WRITE duration is one cycle.
- `busy` is registered and tracks the state/FIFO of the previous edge: one cycle of lag relative to the FIFO count.
- Maximum throughput is one write per 2 cycles without verify, and one per 3 cycles with it.

## Configuration
- `MEM_WR_VERIFY_EN` defined:
  - READ state present;
  - `mem_re` driven;
  - `err` is live;
  - each transaction performs a write followed by a readback.
- `MEM_WR_VERIFY_EN` not defined:
  - no READ state;
  - `mem_re` and `err` tied to 0;
  - `mem_rdata` unused.

## Test plan
- Single press: `enable` 0→1 with addr=6, data=9, held 20 cycles, `mem_ack` returned 1 cycle after `mem_we` → exactly one write of (6,9); `wr_count`=1; `busy` returns to 0.
- Held level / reset edge: `enable`=1 throughout reset and for 10 cycles after reset release → no write; `wr_count`=0.
- Back-to-back: presses (6,9) then (0,8) 3 cycles apart, `mem_ack` delayed 5 cycles → writes issued in order; `mem_addr`/`mem_wdata` stable during each wait; `wr_count`=2.
- Overflow: `mem_ack` held 0, then DEPTH+1=5 presses → first 4 queued, 5th dropped, `overflow`=1. Release `mem_ack` → exactly 4 writes; `overflow` stays 1.
- Verify (macro on): write (6,9), readback model returns 7 → `err`=1. Readback returning 9 → `err` stays 0.
- Reset mid-write: `rst_n` low while `mem_we`=1 and 2 entries queued → all outputs 0 immediately; after release, no writes occur without a new press.

Source files
------------

// File: rtl/mem_write_ctrl.sv
// Turns a level-held write request into one acknowledged memory write per press,
// buffered through a small FIFO. Define MEM_WR_VERIFY_EN to add a readback check.
module mem_write_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              overflow,
    output logic              err,
    output logic [7:0]        wr_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              en_q;
    logic [PTR_W:0]    wptr_q;
    logic [PTR_W:0]    rptr_q;
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];

    logic push_c;
    logic push_ok_c;
    logic pop_c;
    logic load_c;
    logic empty_c;
    logic full_c;
`ifdef MEM_WR_VERIFY_EN
    logic rd_done_c;
`endif

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign empty_c   = (wptr_q == rptr_q);
    assign full_c    = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                       (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign push_c    = enable && !en_q;
    assign push_ok_c = push_c && (!full_c || pop_c);

    // Next-state and transaction strobes
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        pop_c   = 1'b0;
`ifdef MEM_WR_VERIFY_EN
        rd_done_c = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!empty_c) begin
                    load_c  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    pop_c = 1'b1;
`ifdef MEM_WR_VERIFY_EN
                    state_d = READ;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef MEM_WR_VERIFY_EN
            READ: begin
                if (mem_ack) begin
                    rd_done_c = 1'b1;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // en_q resets high so a level already asserted at reset release is not a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            en_q      <= 1'b1;
            wptr_q    <= '0;
            rptr_q    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            wr_count  <= 8'd0;
        end else begin
            state_q <= state_d;
            en_q    <= enable;
            busy    <= (state_q != IDLE) || !empty_c;
            if (push_ok_c) begin
                wptr_q <= wptr_q + (PTR_W+1)'(1);
            end
            if (push_c && !push_ok_c) begin
                overflow <= 1'b1;
            end
            if (pop_c) begin
                rptr_q   <= rptr_q + (PTR_W+1)'(1);
                wr_count <= wr_count + 8'd1;
            end
            if (load_c) begin
                mem_we    <= 1'b1;
                mem_addr  <= fifo_addr[rptr_q[PTR_W-1:0]];
                mem_wdata <= fifo_data[rptr_q[PTR_W-1:0]];
            end else if (pop_c) begin
                mem_we <= 1'b0;
            end
        end
    end

    // FIFO storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            fifo_addr[wptr_q[PTR_W-1:0]] <= addr;
            fifo_data[wptr_q[PTR_W-1:0]] <= data;
        end
    end

`ifdef MEM_WR_VERIFY_EN
    // Readback strobe and sticky mismatch flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_re <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (pop_c) begin
                mem_re <= 1'b1;
            end else if (rd_done_c) begin
                mem_re <= 1'b0;
            end
            if (rd_done_c && (mem_rdata != mem_wdata)) begin
                err <= 1'b1;
            end
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign mem_re       = 1'b0;
    assign err          = 1'b0;
`endif

endmodule
